// File: rtl/hamming_seq_ctrl.sv
// Sequencer for the combinational Hamming (7,4) check/display datapath: captures operands,
// holds them for SETTLE_CYCLES, then latches results. Optional bit-flip injection via ERR_INJECT_EN.
module hamming_seq_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [3:0]       entrada_i,
  input  logic [6:0]       palabra_i,
`ifdef ERR_INJECT_EN
  input  logic [2:0]       inject_i,
`endif
  output logic [3:0]       dp_entrada_o,
  output logic [6:0]       dp_palabra_o,
  output logic             dp_valid_o,
  input  logic [6:0]       dp_siete_seg_i,
  input  logic [3:0]       dp_led_i,
  input  logic             dp_error_i,
  output logic [6:0]       siete_seg_o,
  output logic [3:0]       led_o,
  output logic             error_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] err_count_o
);

  localparam int unsigned      SCW         = 4;
  localparam logic [SCW-1:0]   SETTLE_LOAD = SCW'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [SCW-1:0]    cnt_q, cnt_d;
  logic [3:0]        dp_entrada_q, dp_entrada_d;
  logic [6:0]        dp_palabra_q, dp_palabra_d;
  logic              dp_valid_q, dp_valid_d;
  logic [6:0]        siete_seg_q, siete_seg_d;
  logic [3:0]        led_q, led_d;
  logic              error_q, error_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic [6:0]        inj_mask_c;

  // Code-word bit to invert at capture (all zero when injection is not built in)
`ifdef ERR_INJECT_EN
  always_comb begin
    inj_mask_c = '0;
    if (inject_i != 3'd0) inj_mask_c[inject_i - 3'd1] = 1'b1;
  end
`else
  assign inj_mask_c = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dp_entrada_q <= '0;
      dp_palabra_q <= '0;
      dp_valid_q   <= 1'b0;
      siete_seg_q  <= '0;
      led_q        <= '0;
      error_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dp_entrada_q <= dp_entrada_d;
      dp_palabra_q <= dp_palabra_d;
      dp_valid_q   <= dp_valid_d;
      siete_seg_q  <= siete_seg_d;
      led_q        <= led_d;
      error_q      <= error_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_count_q  <= err_count_d;
    end
  end

  // Next-state and next-output logic; everything holds unless a transition updates it
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dp_entrada_d = dp_entrada_q;
    dp_palabra_d = dp_palabra_q;
    dp_valid_d   = dp_valid_q;
    siete_seg_d  = siete_seg_q;
    led_d        = led_q;
    error_d      = error_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_count_d  = err_count_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          dp_entrada_d = entrada_i;
          dp_palabra_d = palabra_i ^ inj_mask_c;
          dp_valid_d   = 1'b1;
          busy_d       = 1'b1;
          cnt_d        = SETTLE_LOAD;
          state_d      = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - SCW'(1);
        end else begin
          siete_seg_d = dp_siete_seg_i;
          led_d       = dp_led_i;
          error_d     = dp_error_i;
          done_d      = 1'b1;
          dp_valid_d  = 1'b0;
          busy_d      = 1'b0;
          if (dp_error_i && (err_count_q != CNT_MAX)) err_count_d = err_count_q + CNT_W'(1);
          state_d     = IDLE;
        end
      end
    endcase
  end

  assign dp_entrada_o = dp_entrada_q;
  assign dp_palabra_o = dp_palabra_q;
  assign dp_valid_o   = dp_valid_q;
  assign siete_seg_o  = siete_seg_q;
  assign led_o        = led_q;
  assign error_o      = error_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_count_o  = err_count_q;

endmodule

// File: tb/tb_hamming_seq_ctrl.sv
// Scoreboard bench for hamming_seq_ctrl: driver pushes expected results, monitor checks each cycle.
// A second instance with a 2-bit counter exercises saturation on the same stimulus.
module tb_hamming_seq_ctrl;

  localparam int S = 2;

  logic       clk_i, rst_n_i, start_i;
  logic [3:0] entrada_i;
  logic [6:0] palabra_i;
  logic [2:0] inject_i;

  logic [3:0] dp_entrada_o, s_dp_entrada_o;
  logic [6:0] dp_palabra_o, s_dp_palabra_o;
  logic       dp_valid_o, s_dp_valid_o;
  logic [6:0] dp_siete_seg_i, s_dp_siete_seg_i;
  logic [3:0] dp_led_i, s_dp_led_i;
  logic       dp_error_i, s_dp_error_i;
  logic [6:0] siete_seg_o, s_siete_seg_o;
  logic [3:0] led_o, s_led_o;
  logic       error_o, s_error_o;
  logic       busy_o, s_busy_o;
  logic       done_o, s_done_o;
  logic [7:0] err_count_o;
  logic [1:0] s_err_count_o;

  // Behavioural datapath stubs
  assign dp_siete_seg_i   = dp_palabra_o;
  assign dp_led_i         = dp_entrada_o;
  assign dp_error_i       = (dp_palabra_o != 7'b0) && dp_palabra_o[0];
  assign s_dp_siete_seg_i = s_dp_palabra_o;
  assign s_dp_led_i       = s_dp_entrada_o;
  assign s_dp_error_i     = (s_dp_palabra_o != 7'b0) && s_dp_palabra_o[0];

  hamming_seq_ctrl #(.SETTLE_CYCLES(S), .CNT_W(8)) u_dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i),
    .entrada_i(entrada_i), .palabra_i(palabra_i),
`ifdef ERR_INJECT_EN
    .inject_i(inject_i),
`endif
    .dp_entrada_o(dp_entrada_o), .dp_palabra_o(dp_palabra_o), .dp_valid_o(dp_valid_o),
    .dp_siete_seg_i(dp_siete_seg_i), .dp_led_i(dp_led_i), .dp_error_i(dp_error_i),
    .siete_seg_o(siete_seg_o), .led_o(led_o), .error_o(error_o),
    .busy_o(busy_o), .done_o(done_o), .err_count_o(err_count_o)
  );

  hamming_seq_ctrl #(.SETTLE_CYCLES(S), .CNT_W(2)) u_sat (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i),
    .entrada_i(entrada_i), .palabra_i(palabra_i),
`ifdef ERR_INJECT_EN
    .inject_i(inject_i),
`endif
    .dp_entrada_o(s_dp_entrada_o), .dp_palabra_o(s_dp_palabra_o), .dp_valid_o(s_dp_valid_o),
    .dp_siete_seg_i(s_dp_siete_seg_i), .dp_led_i(s_dp_led_i), .dp_error_i(s_dp_error_i),
    .siete_seg_o(s_siete_seg_o), .led_o(s_led_o), .error_o(s_error_o),
    .busy_o(s_busy_o), .done_o(s_done_o), .err_count_o(s_err_count_o)
  );

  typedef struct {
    int         edge_n;
    logic [6:0] pal;
    logic [3:0] ent;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_e = -1000;
  int         next_ok = 0;
  int         err_total = 0;
  logic [6:0] h_seg = '0;
  logic [3:0] h_led = '0;
  logic       h_err = 1'b0;
  logic [6:0] h_pal = '0;
  logic [3:0] h_ent = '0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic clear_model();
    sb.delete();
    err_total = 0;
    last_e = -1000;
    next_ok = 0;
    h_seg = '0; h_led = '0; h_err = 1'b0; h_pal = '0; h_ent = '0;
  endtask

  // Request a check on the next edge; the model records it only if the block will be idle then
  task automatic issue(input logic [3:0] ent, input logic [6:0] pal, input logic [2:0] inj);
    exp_t       x;
    int         e;
    logic [6:0] cap;
    @(negedge clk_i);
    start_i = 1'b1; entrada_i = ent; palabra_i = pal; inject_i = inj;
    e = cyc + 1;
    if (e >= next_ok) begin
      cap = pal;
`ifdef ERR_INJECT_EN
      if (inj != 3'd0) cap[int'(inj) - 1] = ~cap[int'(inj) - 1];
`endif
      x.edge_n = e + S;
      x.pal = cap;
      x.ent = ent;
      x.err = (cap != 7'b0) && cap[0];
      sb.push_back(x);
      last_e = e;
      next_ok = e + S + 1;
    end
  endtask

  // Idle cycles with start low and the operand inputs scrambled
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_i);
      start_i = 1'b0;
      entrada_i = 4'($urandom);
      palabra_i = 7'($urandom);
      inject_i = 3'($urandom);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_seg"}, 32'(siete_seg_o), 0);
    chk({tag, "_led"}, 32'(led_o), 0);
    chk({tag, "_err"}, 32'(error_o), 0);
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_done"}, 32'(done_o), 0);
    chk({tag, "_valid"}, 32'(dp_valid_o), 0);
    chk({tag, "_dp_pal"}, 32'(dp_palabra_o), 0);
    chk({tag, "_dp_ent"}, 32'(dp_entrada_o), 0);
    chk({tag, "_cnt"}, 32'(err_count_o), 0);
    chk({tag, "_sat_cnt"}, 32'(s_err_count_o), 0);
  endtask

  // Asynchronous reset while a check is in flight
  task automatic mid_reset();
    @(negedge clk_i);
    start_i = 1'b0;
    #2 rst_n_i = 1'b0;
    #1 check_all_zero("mid_reset");
    clear_model();
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  // Monitor: checks every cycle after the active edge, pops on done_o
  initial begin
    int   n;
    logic bexp;
    exp_t x;
    forever begin
      @(posedge clk_i);
      #1;
      n = cyc;
      bexp = (n >= last_e) && (n < last_e + S);
      chk("busy", 32'(busy_o), 32'(bexp));
      chk("dp_valid", 32'(dp_valid_o), 32'(bexp));
      if (done_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(done_o), 0);
        end else begin
          x = sb.pop_front();
          chk("done_edge", 32'(n), 32'(x.edge_n));
          h_seg = x.pal; h_led = x.ent; h_err = x.err; h_pal = x.pal; h_ent = x.ent;
          err_total += int'(x.err);
        end
      end else if (sb.size() != 0 && sb[0].edge_n <= n) begin
        chk("missing_done", 32'(done_o), 1);
        x = sb.pop_front();
      end
      chk("sat_done", 32'(s_done_o), 32'(done_o));
      chk("siete_seg", 32'(siete_seg_o), 32'(h_seg));
      chk("led", 32'(led_o), 32'(h_led));
      chk("error", 32'(error_o), 32'(h_err));
      chk("err_count", 32'(err_count_o), 32'(sat(err_total, 255)));
      chk("sat_err_count", 32'(s_err_count_o), 32'(sat(err_total, 3)));
      if (!bexp && n > last_e) begin
        chk("dp_palabra_hold", 32'(dp_palabra_o), 32'(h_pal));
        chk("dp_entrada_hold", 32'(dp_entrada_o), 32'(h_ent));
      end
    end
  end

  // Driver
  initial begin
    rst_n_i = 1'b0; start_i = 1'b0; entrada_i = '0; palabra_i = '0; inject_i = '0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    idle(2);

    // Single check: no error
    issue(4'b0011, 7'b1101100, 3'd0);
    idle(4);

    // Held start: three back-to-back error checks
    repeat (7) issue(4'b0101, 7'b0000001, 3'd0);
    idle(4);

    // Start pulses while busy are ignored
    issue(4'b1001, 7'b0110110, 3'd0);
    issue(4'b1111, 7'b1111111, 3'd0);
    issue(4'b1110, 7'b0000011, 3'd0);
    idle(4);

    // Two more error checks: 5 total, 2-bit counter saturates at 3
    issue(4'b0001, 7'b0000001, 3'd0);
    idle(3);
    issue(4'b0010, 7'b1010101, 3'd0);
    idle(4);

`ifdef ERR_INJECT_EN
    issue(4'b0000, 7'b0000000, 3'd1);
    idle(4);
`endif

    // Reset in the middle of a settle window
    issue(4'b1010, 7'b0001111, 3'd0);
    mid_reset();
    idle(4);

    // Randomised traffic
    repeat (300) begin
      if ($urandom_range(0, 2) != 0) begin
`ifdef ERR_INJECT_EN
        issue(4'($urandom), 7'($urandom), 3'($urandom));
`else
        issue(4'($urandom), 7'($urandom), 3'd0);
`endif
      end else begin
        idle(1);
      end
    end
    idle(6);
    chk("scoreboard_drained", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
